// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizes and tag/pointer types for the rename free list
package free_list_pkg;

  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_GEN_REG  = 32;
  localparam int FL_SIZE      = NUM_PHYS_REG - NUM_GEN_REG;
  localparam int PTR_W        = $clog2(FL_SIZE) + 1;
  localparam int IDX_W        = $clog2(FL_SIZE);
  localparam int PHYS_IDX_W   = $clog2(NUM_PHYS_REG);
  localparam int PHYS_REG_W   = PHYS_IDX_W + 1;

  // Pointer including the wrap bit, tag without the ready bit, tag with it.
  typedef logic [PTR_W-1:0]      fl_ptr_t;
  typedef logic [PHYS_IDX_W-1:0] phys_idx_t;
  typedef logic [PHYS_REG_W-1:0] phys_reg_t;

  // Tail after reset: every slot full, so the wrap bit is set.
  localparam fl_ptr_t FL_TAIL_RESET = fl_ptr_t'(FL_SIZE);

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free physical register tags with checkpoint restore
module free_list
  import free_list_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dispatch_en,
  input  logic                  retire_en,
  input  logic [PHYS_REG_W-1:0] retire_tag,
  input  logic                  branch_incorrect,
  input  logic [PTR_W-1:0]      head_checkpoint,
  output logic [PHYS_REG_W-1:0] free_reg,
  output logic                  free_valid,
  output logic [PTR_W-1:0]      head_out,
  output logic [PTR_W-1:0]      count,
  output logic                  overflow_err
);

  phys_idx_t entries_q [FL_SIZE];
  fl_ptr_t   head_q, head_d;
  fl_ptr_t   tail_q, tail_d;
  logic      ovf_q, ovf_d;

  fl_ptr_t   count_w;
  logic      full;
  logic      pop;
  logic      push;

  // The ready bit of the retiring tag carries no meaning for a free register.
  logic      unused_ready;
  assign unused_ready = retire_tag[PHYS_REG_W-1];

  // Occupancy and outputs; the head entry is presented with zero latency.
  always_comb begin
    count_w    = tail_q - head_q;
    full       = (count_w == fl_ptr_t'(FL_SIZE));
    free_valid = (count_w != '0);
    count      = count_w;
    head_out   = head_q;
    free_reg   = {1'b0, entries_q[head_q[IDX_W-1:0]]};
  end

  // Pointer next-state: recovery overrides a pop, a push still lands at the old tail.
  always_comb begin
    pop    = dispatch_en & free_valid & ~branch_incorrect;
    push   = retire_en & ~full;
    head_d = head_q;
    tail_d = tail_q;
    ovf_d  = ovf_q | (retire_en & full);
    if (branch_incorrect) begin
      head_d = head_checkpoint;
    end else if (pop) begin
      head_d = head_q + fl_ptr_t'(1);
    end
    if (push) begin
      tail_d = tail_q + fl_ptr_t'(1);
    end
  end

  // State and storage; storage is never cleared so recovered tags reappear.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= FL_TAIL_RESET;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FL_SIZE; i++) begin
        entries_q[i] <= phys_idx_t'(NUM_GEN_REG + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      if (push) begin
        entries_q[tail_q[IDX_W-1:0]] <= retire_tag[PHYS_IDX_W-1:0];
      end
    end
  end

  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for the rename free list
module tb_free_list;

  logic       clock;
  logic       reset;
  logic       dispatch_en;
  logic       retire_en;
  logic [6:0] retire_tag;
  logic       branch_incorrect;
  logic [5:0] head_checkpoint;
  logic [6:0] free_reg;
  logic       free_valid;
  logic [5:0] head_out;
  logic [5:0] count;
  logic       overflow_err;

  int checks;
  int errors;
  logic [5:0] exp_q[$];

  free_list dut (
    .clock(clock),
    .reset(reset),
    .dispatch_en(dispatch_en),
    .retire_en(retire_en),
    .retire_tag(retire_tag),
    .branch_incorrect(branch_incorrect),
    .head_checkpoint(head_checkpoint),
    .free_reg(free_reg),
    .free_valid(free_valid),
    .head_out(head_out),
    .count(count),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_en      = 1'b0;
    retire_en        = 1'b0;
    retire_tag       = '0;
    branch_incorrect = 1'b0;
    head_checkpoint  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
  endtask

  // Pop n tags, comparing each presented tag with the scoreboard head.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (free_valid !== 1'b1 || free_reg !== {1'b0, exp_q[0]}) begin
        errors++;
        $display("FAIL drain_pop[%0d]: free_reg=%0d valid=%0b expected %0d valid=1", i, free_reg, free_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
      dispatch_en = 1'b1;
      step();
    end
    dispatch_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", count); end
    checks++; if (free_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %0b expected 1", free_valid); end
    checks++; if (free_reg !== 7'd32) begin errors++; $display("FAIL reset_free_reg: got %0d expected 32", free_reg); end
    checks++; if (head_out !== 6'd0) begin errors++; $display("FAIL reset_head: got %0d expected 0", head_out); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow_err); end
  endtask

  task automatic test_dispatch();
    do_reset();
    drain(3);
    checks++; if (count !== 6'd29) begin errors++; $display("FAIL dispatch_count: got %0d expected 29", count); end
    checks++; if (head_out !== 6'd3) begin errors++; $display("FAIL dispatch_head: got %0d expected 3", head_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    retire_en  = 1'b1;
    retire_tag = 7'h45;
    step();
    idle_inputs();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow_err); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL ovf_count: got %0d expected 32", count); end
    step();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow_err); end
    do_reset();
    drain(32);
    retire_en  = 1'b1;
    retire_tag = 7'd5;
    checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL push_empty_valid: got %0b expected 0", free_valid); end
    exp_q.push_back(6'd5);
    step();
    idle_inputs();
    checks++; if (free_valid !== 1'b1) begin errors++; $display("FAIL push_next_valid: got %0b expected 1", free_valid); end
    checks++; if (free_reg !== 7'd5) begin errors++; $display("FAIL push_next_tag: got %0d expected 5", free_reg); end
  endtask

  task automatic test_empty();
    do_reset();
    drain(32);
    dispatch_en = 1'b1;
    step();
    step();
    dispatch_en = 1'b0;
    checks++; if (head_out !== 6'd32) begin errors++; $display("FAIL empty_head: got %0d expected 32", head_out); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", count); end
    // Push and pop together while empty: pop ignored, tag visible next cycle.
    dispatch_en = 1'b1;
    retire_en   = 1'b1;
    retire_tag  = 7'd7;
    checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL empty_pushpop_valid: got %0b expected 0", free_valid); end
    exp_q.push_back(6'd7);
    step();
    retire_en = 1'b0;
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL empty_pushpop_count: got %0d expected 1", count); end
    dispatch_en = 1'b0;
    drain(1);
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL empty_final_count: got %0d expected 0", count); end
  endtask

  task automatic test_branch();
    do_reset();
    drain(2);
    checks++; if (head_out !== 6'd2) begin errors++; $display("FAIL branch_cp_head: got %0d expected 2", head_out); end
    drain(4);
    checks++; if (head_out !== 6'd6) begin errors++; $display("FAIL branch_pre_head: got %0d expected 6", head_out); end
    branch_incorrect = 1'b1;
    head_checkpoint  = 6'd2;
    dispatch_en      = 1'b1;
    retire_en        = 1'b1;
    retire_tag       = 7'd9;
    step();
    idle_inputs();
    exp_q.delete();
    for (int i = 34; i < 64; i++) exp_q.push_back(6'(i));
    exp_q.push_back(6'd9);
    checks++; if (head_out !== 6'd2) begin errors++; $display("FAIL branch_head: got %0d expected 2", head_out); end
    checks++; if (free_reg !== 7'd34) begin errors++; $display("FAIL branch_free_reg: got %0d expected 34", free_reg); end
    checks++; if (count !== 6'd31) begin errors++; $display("FAIL branch_count: got %0d expected 31", count); end
    drain(30);
    checks++; if (free_reg !== 7'd9) begin errors++; $display("FAIL branch_tail_tag: got %0d expected 9", free_reg); end
  endtask

  task automatic test_random();
    logic [5:0] h;
    logic       p, q;
    logic [6:0] t;
    do_reset();
    drain(16);
    h = 6'd16;
    for (int c = 0; c < 100; c++) begin
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      if (exp_q.size() <= 1) p = 1'b0;
      if (exp_q.size() >= 31) q = 1'b0;
      t = 7'($urandom_range(0, 127));
      if (p) begin
        checks++;
        if (free_reg !== {1'b0, exp_q[0]}) begin
          errors++;
          $display("FAIL rand_pop[%0d]: got %0d expected %0d", c, free_reg, exp_q[0]);
        end
        void'(exp_q.pop_front());
        h = h + 6'd1;
      end
      if (q) exp_q.push_back(t[5:0]);
      dispatch_en = p;
      retire_en   = q;
      retire_tag  = t;
      step();
      idle_inputs();
      checks++;
      if (count !== 6'(exp_q.size()) || head_out !== h) begin
        errors++;
        $display("FAIL rand_state[%0d]: count=%0d head=%0d expected count=%0d head=%0d", c, count, head_out, exp_q.size(), h);
      end
    end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rand_ovf: got %0b expected 0", overflow_err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drain(22);
    checks++; if (count !== 6'd10) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 10", count); end
    reset       = 1'b1;
    dispatch_en = 1'b1;
    retire_en   = 1'b1;
    retire_tag  = 7'd3;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL midrst_count: got %0d expected 32", count); end
    checks++; if (free_reg !== 7'd32) begin errors++; $display("FAIL midrst_free_reg: got %0d expected 32", free_reg); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %0b expected 0", overflow_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_dispatch();
    test_overflow();
    test_empty();
    test_branch();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of unallocated physical register tags.
- Sits directly upstream of the rename map table and supplies the free_reg tag it writes on dispatch.
- Refilled at retire with the previous mapping (T_old) released by the ROB.
- Exports its head pointer so branch checkpoints can capture it, and restores that pointer on a mispredict.

Parameters:
- NUM_PHYS_REG, 64, total physical registers; the tag index is $clog2(NUM_PHYS_REG) = 6 bits.
- NUM_GEN_REG, 32, architectural registers, identity-mapped at reset.
- FL_SIZE, NUM_PHYS_REG-NUM_GEN_REG = 32, FIFO depth.
- PTR_W, $clog2(FL_SIZE)+1 = 6, pointer width including the wrap bit.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dispatch_en  in  1  pop one tag this cycle (rename consumes free_reg)
- retire_en  in  1  push retire_tag this cycle
- retire_tag  in  PHYS_REG (7)  T_old from the ROB; bit 6 (ready) is ignored
- branch_incorrect  in  1  mispredict recovery
- head_checkpoint  in  PTR_W  head value saved at branch dispatch
- free_reg  out  PHYS_REG (7)  tag at head; bit 6 is always 0 (not ready)
- free_valid  out  1  FIFO non-empty
- head_out  out  PTR_W  current head, for checkpointing
- count  out  PTR_W  entries held, 0..FL_SIZE
- overflow_err  out  1  sticky: push attempted while full

Behaviour:
- Storage: FL_SIZE entries of 6-bit index; head/tail are PTR_W pointers; the index is the low 5 bits.
- count = tail - head, modulo 2^PTR_W.
- free_valid = (count != 0); full = (count == FL_SIZE).
- Reset:
  - entry[i] = NUM_GEN_REG+i (PR32..PR63); head=0, tail=FL_SIZE with wrap bit set (6'b100000).
  - count=32, free_valid=1, free_reg=7'd32, head_out=0, overflow_err=0.
- free_reg is combinational from entry[head]; zero read latency. A pop takes effect at the next clock edge.
- Pop: dispatch_en & free_valid & !branch_incorrect -> head+1. A pop while empty is ignored; free_reg content is don't-care while free_valid=0.
- Push: retire_en & !full -> entry[tail] = retire_tag[5:0], tail+1. A push while full is dropped, and overflow_err sets and stays set until reset.
- Simultaneous pop and push, not empty: both occur, count unchanged.
- Simultaneous pop and push, empty: no bypass; free_valid=0 this cycle, and next cycle count=1 and free_reg=the pushed tag.
- Simultaneous pop and push, full: the pop frees a slot but the push still sees full; the push is dropped and overflow_err sets. Full cannot occur in a correct design.
- branch_incorrect:
  - next head = head_checkpoint; tail is unchanged.
  - A same-cycle push still applies at the old tail.
  - A same-cycle pop is ignored; recovery has priority.
  - Tags popped after the checkpoint reappear automatically because the storage is not cleared.
- Wrap-around: pointers roll over mod 2^PTR_W; the wrap bit distinguishes full from empty.
- Retire tags may arrive in any order; no duplicate checking is done.
- reset asserted mid-operation overrides all other inputs that edge.

Decomposition:
- Add to sys_defs.vh:
  - FL_SIZE
  - FL_PTR_T (logic [PTR_W-1:0])
  - PHYS_IDX_T (6-bit tag index without the ready bit)
- PHYS_REG and NUM_PHYS_REG are reused from sys_defs.vh.
- Single module, no sub-module. Pointer/count arithmetic stays inline; the storage array is a flop array.

Test Plan:
- Reset, then dispatch_en for 3 cycles -> free_reg sequence 32,33,34; count 29; head_out=3.
- From reset, retire_en with retire_tag=7'h45 (ready bit set) and no pop -> overflow_err=1, count stays 32. Separately, drain 32 pops then push tag 5 -> free_valid=0 during the push cycle, next cycle free_valid=1, free_reg=7'd5, bit6=0.
- Drain to empty, then dispatch_en=1 with retire_en=0 for 2 cycles -> head does not move, count=0. Then push 7 and pop 7 in the same cycle -> count=0 afterwards, no pop issued on the empty cycle.
- Record head_out=2 as the checkpoint; pop 4 (head=6); in the same cycle assert branch_incorrect (head_checkpoint=2), dispatch_en=1, retire_en=1 with tag 9 -> next head=2, free_reg=34, tail advanced by 1, count=31.
- Run 100 cycles of random pop/push with occupancy kept between 1 and 31 -> scoreboard FIFO order matches, pointers wrap cleanly, count always equals the model.
- Assert reset mid-stream with count=10 -> next cycle count=32, free_reg=32, overflow_err=0.
